carrier_sense: RTL

- Listen-before-talk gate that sits directly upstream of tx_buffer_inband in the inband TX path.
- Consumes the adc_interface RSSI words and the rssi_threshhold / rssi_wait values from register_io.
- Tells the TX buffer when the channel has been quiet long enough to start sending a packet, or when waiting for quiet has timed out.

---
 rtl/carrier_sense.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/carrier_sense.sv
// carrier_sense: listen-before-talk gate in front of the inband TX buffer.
// Samples the selected RSSI word, waits for QUIET_CYCLES consecutive quiet
// cycles before granting the channel, and optionally gives up after a
// programmable number of sensing cycles.
module carrier_sense #(
  parameter int QUIET_CYCLES = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       chan_sel,
  input  logic [31:0]      rssi_0,
  input  logic [31:0]      rssi_1,
  input  logic [31:0]      rssi_2,
  input  logic [31:0]      rssi_3,
  input  logic [31:0]      threshhold,
  input  logic [CNT_W-1:0] rssi_wait,
  input  logic             tx_req,
  input  logic             tx_done,
  output logic             tx_grant,
  output logic             timeout,
  output logic             sensing,
  output logic [15:0]      busy_count,
  output logic [15:0]      debugbus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SENSE = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [15:0]      QUIET_LAST = 16'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [31:0]      rssi_sel, rssi_q;
  logic [31:0]      thr_l, thr_l_n;
  logic [CNT_W-1:0] wait_l, wait_l_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic [15:0]      quiet_cnt, quiet_cnt_n;
  logic [15:0]      busy_count_n;
  logic             tx_grant_n, timeout_n, sensing_n;
  logic             quiet;

  // Pick the sensed channel; registered below, so every compare lags one cycle.
  always_comb begin
    unique case (chan_sel)
      2'd0:    rssi_sel = rssi_0;
      2'd1:    rssi_sel = rssi_1;
      2'd2:    rssi_sel = rssi_2;
      default: rssi_sel = rssi_3;
    endcase
  end

  // Quiet uses the threshold captured at SENSE entry, not the live register.
  assign quiet = (rssi_q <= thr_l);

  // Next-state, counters and registered outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n      = state;
    thr_l_n      = thr_l;
    wait_l_n     = wait_l;
    wait_cnt_n   = wait_cnt;
    quiet_cnt_n  = quiet_cnt;
    busy_count_n = busy_count;
    timeout_n    = 1'b0;

    if (!enable) begin
      // Disabled: drop straight to IDLE, no timeout, busy_count frozen.
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_req) begin
            thr_l_n      = threshhold;
            wait_l_n     = rssi_wait;
            wait_cnt_n   = '0;
            quiet_cnt_n  = '0;
            busy_count_n = '0;
            state_n      = (threshhold == 32'd0) ? GRANT : SENSE;
          end
        end
        SENSE: begin
          if (wait_cnt != CNT_MAX) wait_cnt_n = wait_cnt + CNT_ONE;
          if (quiet) begin
            if (quiet_cnt != 16'hFFFF) quiet_cnt_n = quiet_cnt + 16'd1;
          end else begin
            quiet_cnt_n = '0;
            if (busy_count != 16'hFFFF) busy_count_n = busy_count + 16'd1;
          end
          // Grant wins over timeout when both land on the same cycle.
          if (quiet && (quiet_cnt == QUIET_LAST)) begin
            state_n = GRANT;
          end else if ((wait_l != '0) && (wait_cnt == wait_l - CNT_ONE)) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
          end
        end
        GRANT: begin
          // A tx_req alongside tx_done is ignored; IDLE re-arms on its own.
          if (tx_done) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    // Grant output follows the state by one cycle and drops with the exit edge.
    tx_grant_n = (state == GRANT) && (state_n == GRANT);
    sensing_n  = (state_n == SENSE);
  end

  // State, counters, latched settings and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rssi_q     <= '0;
      thr_l      <= '0;
      wait_l     <= '0;
      wait_cnt   <= '0;
      quiet_cnt  <= '0;
      busy_count <= '0;
      tx_grant   <= 1'b0;
      timeout    <= 1'b0;
      sensing    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      rssi_q     <= rssi_sel;
      thr_l      <= thr_l_n;
      wait_l     <= wait_l_n;
      wait_cnt   <= wait_cnt_n;
      quiet_cnt  <= quiet_cnt_n;
      busy_count <= busy_count_n;
      tx_grant   <= tx_grant_n;
      timeout    <= timeout_n;
      sensing    <= sensing_n;
    end
  end

  assign debugbus = {state, quiet_cnt[5:0], busy_count[7:0]};

endmodule
